// File: rtl/note_dropper_param.sv
// note_dropper_param: parametrised single-note falling-arrow engine with press-edge hits, graded scoring and miss reporting.
// Defining NOTE_DROPPER_PERFECT_EN grades hits inside [PERF_LO, PERF_HI) as perfect (grade 2); otherwise every hit is grade 1.
module note_dropper_param #(
  parameter int X_START = 500,
  parameter int Y_START = 100,
  parameter int Y_MAX = 400,
  parameter int NOTE_H = 40,
  parameter int DELAY = 2060,
  parameter int SPEED = 1,
  parameter logic [7:0] LANE_KEY = 8'h4f,
  parameter logic [7:0] START_KEY = 8'h2c,
  parameter logic [7:0] RESTART_KEY = 8'h01,
  parameter int HIT_LO = 340,
  parameter int HIT_HI = 400,
  parameter int PERF_LO = 360,
  parameter int PERF_HI = 380
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode_second,
  output logic [9:0] dropX,
  output logic [9:0] dropY,
  output logic       visible,
  output logic       score,
  output logic [1:0] grade,
  output logic       miss
);
  localparam int CW = DELAY == 0 ? 1 : $clog2(DELAY + 1);
  localparam logic [CW-1:0] LAST = CW'(DELAY == 0 ? 0 : DELAY - 1);
`ifdef NOTE_DROPPER_PERFECT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif
  typedef enum logic [2:0] {HALTED, WAIT, FALL, HIT, MISS} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic key_prev;
  logic lane;
  logic start;
  logic restart;
  logic press;
  logic [10:0] bottom;
  logic in_win;
  logic in_perf;
  assign lane = keycode == LANE_KEY || keycode_second == LANE_KEY;
  assign start = keycode == START_KEY || keycode_second == START_KEY;
  assign restart = keycode == RESTART_KEY || keycode_second == RESTART_KEY;
  assign press = lane && !key_prev;
  // bottom edge kept one bit wider than Y so an overshoot past Y_MAX cannot wrap
  assign bottom = {1'b0, dropY} + 11'(NOTE_H);
  assign in_win = bottom >= 11'(HIT_LO) && bottom < 11'(HIT_HI);
  assign in_perf = bottom >= 11'(PERF_LO) && bottom < 11'(PERF_HI);
  assign dropX = 10'(X_START);
  // note lifecycle: arm, delay, fall, then hold the hit/miss result until restart
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= HALTED;
      dropY <= 10'(Y_START);
      count <= '0;
      key_prev <= 1'b0;
      score <= 1'b0;
      grade <= 2'd0;
      miss <= 1'b0;
      visible <= 1'b1;
    end else begin
      key_prev <= lane;
      case (state)
        HALTED: if (start) state <= DELAY == 0 ? FALL : WAIT;
        WAIT: begin
          count <= count + CW'(1);
          if (count == LAST) state <= FALL;
        end
        FALL: begin
          if (bottom >= 11'(Y_MAX)) begin
            state <= MISS;
            miss <= 1'b1;
            visible <= 1'b0;
          end else if (press && in_win) begin
            state <= HIT;
            score <= 1'b1;
            grade <= PERF_EN && in_perf ? 2'd2 : 2'd1;
            visible <= 1'b0;
          end else begin
            dropY <= dropY + 10'(SPEED);
          end
        end
        default: begin
          if (restart) begin
            state <= HALTED;
            dropY <= 10'(Y_START);
            count <= '0;
            score <= 1'b0;
            grade <= 2'd0;
            miss <= 1'b0;
            visible <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
